aes_inv_round_seq: RTL and testbench
====================================

AES_INV_ROUND_SEQ -- requirements
Module: aes_inv_round_seq

Interface
REQ-001 SHALL have parameter UNROLL, default 1: inverse rounds per clock, legal values 1 or 2; any other value SHALL fail elaboration.
REQ-002 SHALL have parameter OUT_REG, default 1: 1 = out_data comes from a register; 0 = same value, but out_data may be combinational from the state register.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 switch  in  2  key length: 00 = AES-128 (nr=10), 01 = AES-192 (nr=12), 10/11 = AES-256 (nr=14); sampled only at accept.
REQ-006 in_valid  in  1  ciphertext block offered.
REQ-007 in_ready  out  1  block can be accepted.
REQ-008 in_data  in  128  ciphertext, byte 0 in bits [127:120].
REQ-009 rk_idx  out  UNROLL*4  round-key index per lane; lane 0 is bits [3:0].
REQ-010 rk  in  UNROLL*128  round keys matching rk_idx, combinational same-cycle supply; lane 0 is bits [127:0].
REQ-011 out_valid  out  1  plaintext available.
REQ-012 out_ready  in  1  consumer accepts plaintext.
REQ-013 out_data  out  128  plaintext.

Function
REQ-014 SHALL implement the FSM states IDLE, ARK, ROUND and DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, latch in_data into the state register, latch nr from switch, and go to ARK.
REQ-016 ARK (1 cycle): rk_idx lane 0 = nr; state <= state ^ rk lane 0; round counter r <= nr-1; go to ROUND.
REQ-017 ROUND, per lane j=0..UNROLL-1 with lane key index r-j: InvShiftRows, then InvSubBytes, then AddRoundKey(rk lane j).
REQ-018 ROUND: InvMixColumns SHALL follow each lane except when the lane key index is 0.
REQ-019 ROUND: lanes SHALL chain combinationally; the state register updates once per cycle; r <= r-UNROLL.
REQ-020 ROUND exits to DONE in the cycle in which a lane uses key index 0.
REQ-021 ROUND SHALL last exactly nr/UNROLL cycles.
REQ-022 Latency: out_valid SHALL rise exactly 1+nr/UNROLL clock edges after the accept edge (UNROLL=1: 11/13/15; UNROLL=2: 6/7/8).
REQ-023 DONE: out_valid=1 and out_data=final state, both held stable until out_ready=1; on out_valid&&out_ready, return to IDLE next edge.
REQ-024 in_ready SHALL be 0 in ARK, ROUND and DONE; in_valid in those states SHALL be ignored and no data latched.
REQ-025 rk_idx SHALL be 0 in IDLE and DONE.
REQ-026 rk_idx lanes not used in the current cycle SHALL be 0.
REQ-027 switch changes after accept SHALL NOT affect the block in flight.
REQ-028 out_ready while out_valid=0 SHALL have no effect.
REQ-029 Back-to-back: after an output handshake, the earliest next accept is the following cycle (IDLE).
REQ-030 Throughput SHALL be one block per 3+nr/UNROLL cycles with out_ready held high.
REQ-031 All byte transforms SHALL be per FIPS-197 inverse cipher, GF(2^8) modulus 0x11B.
REQ-032 InvSubBytes SHALL use combinational ROM with no clocked lookup.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, out_valid=0, in_ready=0, rk_idx=0, state register=0, r=0 and out_data=0, regardless of clk.
REQ-034 in_ready SHALL go to 1 on the first clk edge after rst deasserts.
REQ-035 rst asserted mid-operation SHALL abandon the block, and no out_valid SHALL appear for it.

Verification
REQ-036 AES-128: bench supplies the key schedule of key 000102030405060708090a0b0c0d0e0f via rk_idx; in_data=69c4e0d86a7b0430d8cdb78070b4c55a, switch=00 -> out_data=00112233445566778899aabbccddeeff, out_valid 11 edges after accept (6 for UNROLL=2).
REQ-037 AES-192: key 000102...1617, in_data=dda97ca4864cdfe06eaf70a0ec0d7191, switch=01 -> 00112233445566778899aabbccddeeff after 13 (7) edges.
REQ-038 AES-256: key 000102...1e1f, in_data=8ea2b7ca516745bfeafc49904b496089, switch=11 -> same plaintext after 15 (8) edges.
REQ-039 Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data constant and in_ready=0 throughout; then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 on the next edge.
REQ-040 Mid-operation reset: rst pulsed during the 5th ROUND cycle -> out_valid=0 and in_ready=0 during reset, in_ready=1 after; a subsequent AES-128 vector decrypts correctly.
REQ-041 Protocol: in_valid held high with switch toggled every cycle during ROUND -> only the first block is accepted, its mode is unchanged, and rk_idx sequence is nr, nr-1, ..., 0.

Source files
------------

// File: rtl/aes_inv_round_seq.sv
// Iterative AES inverse cipher (FIPS-197) for 128/192/256-bit keys, UNROLL rounds per clock.
// Round keys come from outside: rk_idx selects them and rk must return them in the same cycle.
module aes_inv_round_seq #(
   parameter int UNROLL  = 1,
   parameter int OUT_REG = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              switch,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [127:0]            in_data,
   output logic [UNROLL*4-1:0]     rk_idx,
   input  logic [UNROLL*128-1:0]   rk,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [127:0]            out_data
);

   generate
      if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
         $error("aes_inv_round_seq: UNROLL must be 1 or 2");
      end
   endgenerate

   // Handshakes: a transfer happens on a rising edge where valid && ready; the source
   // holds data stable while valid is high and not yet accepted.
   typedef enum logic [1:0] {IDLE, ARK, ROUND, DONE} state_t;

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   state_t         r_fsm;
   logic [127:0]   r_data;
   logic [3:0]     r_nr;
   logic [3:0]     r_round;
   logic           r_in_ready;
   logic           r_out_valid;
   logic [127:0]   w_next;
   logic           w_last;

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX[11'd2047 - {x, 3'b000} -: 8];
   endfunction

   // Multiply by a constant whose bits select x, 2x, 4x, 8x (covers 09, 0b, 0d, 0e).
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] x2, x4, x8;
      x2 = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      x4 = {x2[6:0], 1'b0} ^ (x2[7] ? 8'h1b : 8'h00);
      x8 = {x4[6:0], 1'b0} ^ (x4[7] ? 8'h1b : 8'h00);
      return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? a : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
              gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
              gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
              gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
   endfunction

   // Byte b sits at row b%4, column b/4; InvShiftRows moves row r right by r columns.
   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic mix);
      logic [127:0] t;
      for (int c = 0; c < 4; c++) begin
         for (int rr = 0; rr < 4; rr++) begin
            t[127-8*(rr+4*c) -: 8] = inv_sbox(s[127-8*(rr+4*((c-rr+4)%4)) -: 8]);
         end
      end
      t = t ^ k;
      if (mix) begin
         for (int c = 0; c < 4; c++) t[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
      end
      return t;
   endfunction

   always_comb begin
      w_next = r_data;
      for (int j = 0; j < UNROLL; j++) begin
         w_next = inv_round(w_next, rk[128*j +: 128], (r_round - 4'(j)) != 4'd0);
      end
   end

   assign w_last = (r_fsm == ROUND) && (r_round == 4'(UNROLL-1));

   always_comb begin
      rk_idx = '0;
      if (r_fsm == ARK) begin
         rk_idx[3:0] = r_nr;
      end else if (r_fsm == ROUND) begin
         for (int j = 0; j < UNROLL; j++) rk_idx[4*j +: 4] = r_round - 4'(j);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm       <= IDLE;
         r_data      <= '0;
         r_nr        <= '0;
         r_round     <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_data     <= in_data;
                  r_nr       <= (switch == 2'b00) ? 4'd10 : (switch == 2'b01) ? 4'd12 : 4'd14;
                  r_in_ready <= 1'b0;
                  r_fsm      <= ARK;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            ARK: begin
               r_data  <= r_data ^ rk[127:0];
               r_round <= r_nr - 4'd1;
               r_fsm   <= ROUND;
            end
            ROUND: begin
               r_data <= w_next;
               if (w_last) begin
                  r_round     <= '0;
                  r_out_valid <= 1'b1;
                  r_fsm       <= DONE;
               end else begin
                  r_round <= r_round - 4'(UNROLL);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_fsm       <= IDLE;
               end
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [127:0] r_out_data;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) r_out_data <= '0;
            else if (w_last) r_out_data <= w_next;
         end
         assign out_data = r_out_data;
      end else begin : g_out_comb
         assign out_data = r_data;
      end
   endgenerate

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_aes_inv_round_seq.sv
// Directed bench for aes_inv_round_seq: FIPS-197 vectors, backpressure, reset, protocol, throughput.
// The bench builds its own forward S-box and key schedules to feed rk from rk_idx.
module tb_aes_inv_round_seq;
   parameter int UNROLL = 1;
   localparam int W = UNROLL*4;
   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [1:0]            switch = 2'b00;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [127:0]          in_data = '0;
   logic [W-1:0]          rk_idx;
   logic [UNROLL*128-1:0] rk;
   logic                  out_valid;
   logic                  out_ready = 1'b0;
   logic [127:0]          out_data;

   logic [7:0]   sbox [256];
   logic [127:0] rks [16];
   int errors = 0;
   int checks = 0;

   aes_inv_round_seq #(.UNROLL(UNROLL), .OUT_REG(1)) dut (
      .clk(clk), .rst(rst), .switch(switch), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data));

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   always_comb begin
      rk = '0;
      for (int j = 0; j < UNROLL; j++) rk[128*j +: 128] = rks[rk_idx[4*j +: 4]];
   end

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   task automatic build_sbox;
      logic [7:0] inv, s, r;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int c = 1; c < 256; c++) if (gf_mul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
         s = inv; r = inv;
         for (int n = 0; n < 4; n++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
         end
         sbox[x] = s ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   function automatic int nr_of(input logic [1:0] sw);
      return (sw == 2'b00) ? 10 : (sw == 2'b01) ? 12 : 14;
   endfunction

   function automatic int lat_of(input logic [1:0] sw);
      return 1 + nr_of(sw) / UNROLL;
   endfunction

   // Key 00 01 02 ... of the length selected by sw.
   task automatic load_keys(input logic [1:0] sw);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int nk, nr;
      nr = nr_of(sw); nk = nr - 6; rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int k = 0; k < 16; k++) rks[k] = (k <= nr) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : '0;
   endtask

   // driver tasks: all start and end just after a falling edge
   task automatic accept(input logic [1:0] sw, input logic [127:0] ct);
      in_valid = 1'b1; in_data = ct; switch = sw;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: in_ready=%b want 1", in_ready); end
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      while (out_valid !== 1'b1 && k < 40) begin
         @(posedge clk); @(negedge clk); k++;
      end
   endtask

   task automatic handshake(input string name);
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_handshake: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || rk_idx !== '0 || out_data !== '0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b rk_idx=%h out_data=%h want 0", in_ready, out_valid, rk_idx, out_data);
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_release: in_ready=%b want 0", in_ready); end
      @(posedge clk); @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_first_edge: in_ready=%b want 1", in_ready); end
   endtask

   task automatic test_vector(input logic [1:0] sw, input logic [127:0] ct);
      int k;
      load_keys(sw);
      accept(sw, ct);
      wait_valid(k);
      checks++;
      if (k != lat_of(sw)) begin errors++; $display("FAIL vec%0d_latency: got %0d want %0d", nr_of(sw), k, lat_of(sw)); end
      checks++;
      if (out_data !== PT) begin errors++; $display("FAIL vec%0d_data: got %h want %h", nr_of(sw), out_data, PT); end
      handshake("vec");
   endtask

   task automatic test_backpressure;
      int k;
      load_keys(2'b00);
      accept(2'b00, CT128);
      wait_valid(k);
      checks++;
      if (k != lat_of(2'b00)) begin errors++; $display("FAIL bp_latency: got %0d want %0d", k, lat_of(2'b00)); end
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== PT) begin
            errors++;
            $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b data=%h want 1/0/%h", i, out_valid, in_ready, out_data, PT);
         end
         @(posedge clk); @(negedge clk);
      end
      handshake("bp");
   endtask

   task automatic test_mid_reset;
      load_keys(2'b00);
      accept(2'b00, CT128);
      for (int i = 0; i < 5; i++) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b0 || rk_idx !== '0) begin
            errors++;
            $display("FAIL midrst_hold[%0d]: out_valid=%b in_ready=%b rk_idx=%h want 0", i, out_valid, in_ready, rk_idx);
         end
         @(negedge clk);
      end
      rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_after[%0d]: out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
         end
      end
      test_vector(2'b00, CT128);
   endtask

   task automatic test_protocol;
      logic [W-1:0] exp_q [$];
      logic [W-1:0] e;
      int r, k;
      load_keys(2'b00);
      r = nr_of(2'b00) - 1;
      e = '0; e[3:0] = 4'(nr_of(2'b00));
      exp_q.push_back(e);
      while (r >= 0) begin
         e = '0;
         for (int j = 0; j < UNROLL; j++) e[4*j +: 4] = 4'(r - j);
         exp_q.push_back(e);
         r = r - UNROLL;
      end
      in_valid = 1'b1; in_data = CT128; switch = 2'b00;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL proto_ready: in_ready=%b want 1", in_ready); end
      @(posedge clk); @(negedge clk);
      k = 0;
      while (out_valid !== 1'b1 && k < 40) begin
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL proto_busy[%0d]: in_ready=%b want 0", k, in_ready); end
         checks++;
         if (exp_q.size() == 0) begin
            errors++; $display("FAIL proto_rkidx[%0d]: got %h want none", k, rk_idx);
         end else begin
            e = exp_q.pop_front();
            if (rk_idx !== e) begin errors++; $display("FAIL proto_rkidx[%0d]: got %h want %h", k, rk_idx, e); end
         end
         switch = 2'(k + 1);
         in_data = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); @(negedge clk); k++;
      end
      in_valid = 1'b0;
      checks++;
      if (k != lat_of(2'b00) || exp_q.size() != 0) begin
         errors++; $display("FAIL proto_latency: got %0d left %0d want %0d left 0", k, exp_q.size(), lat_of(2'b00));
      end
      checks++;
      if (out_data !== PT) begin errors++; $display("FAIL proto_data: got %h want %h", out_data, PT); end
      handshake("proto");
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL proto_idle[%0d]: out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_back_to_back;
      int L;
      logic expv;
      load_keys(2'b01);
      L = lat_of(2'b01);
      out_ready = 1'b1; in_valid = 1'b1; in_data = CT192; switch = 2'b01;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: in_ready=%b want 1", in_ready); end
      @(posedge clk); @(negedge clk);
      for (int k = 0; k <= 2*L+4; k++) begin
         expv = (k == L) || (k == 2*L+2);
         checks++;
         if (out_valid !== expv) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, out_valid, expv); end
         if (expv) begin
            checks++;
            if (out_data !== PT) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", k, out_data, PT); end
         end
         if (k == L+1) begin
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: in_ready=%b want 1", in_ready); end
         end
         if (k == L+3) in_valid = 1'b0;
         @(posedge clk); @(negedge clk);
      end
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_end: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   initial begin
      for (int k = 0; k < 16; k++) rks[k] = '0;
      build_sbox();
      test_reset();
      test_vector(2'b00, CT128);
      test_vector(2'b01, CT192);
      test_vector(2'b11, CT256);
      test_backpressure();
      test_mid_reset();
      test_protocol();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
